// File: rtl/mbist_march_gen.sv
// March C- MBIST sequencer: drives SRAM ops, supplies ExpDATA, tracks first failure.
// Optional build macro MBIST_STOP_ON_FAIL_EN aborts the test on the first qualified mismatch.
module mbist_march_gen #(
    parameter int                ADDR_W     = 4,
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] BG_PATTERN = {DATA_W{1'b0}}
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              START,
    input  logic              RESULT,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] WDATA,
    output logic              WEN,
    output logic              REN,
    output logic [DATA_W-1:0] ExpDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              FAIL,
    output logic [ADDR_W-1:0] FAIL_ADDR,
    output logic [2:0]        FAIL_ELEM
);

    localparam logic [DATA_W-1:0] D0 = BG_PATTERN;
    localparam logic [DATA_W-1:0] D1 = ~BG_PATTERN;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [2:0]          elem, elem_nxt;
    logic                drain_cnt, drain_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt, exp_nxt;
    logic                wen_nxt, ren_nxt;
    logic                fail_nxt;
    logic [ADDR_W-1:0]   fail_addr_nxt;
    logic [2:0]          fail_elem_nxt;
    logic                start_ok, qual_fail, abort;

    logic                vld_p1, vld_p2;
    logic [ADDR_W-1:0]   addr_p1, addr_p2;
    logic [2:0]          elem_p1, elem_p2;

    function automatic logic is_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic [ADDR_W-1:0] elem_first(input logic [2:0] e);
        return is_down(e) ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
    endfunction

    function automatic logic [ADDR_W-1:0] elem_last(input logic [2:0] e);
        return is_down(e) ? {ADDR_W{1'b0}} : {ADDR_W{1'b1}};
    endfunction

    function automatic logic [DATA_W-1:0] wr_data(input logic [2:0] e);
        return ((e == 3'd1) || (e == 3'd3)) ? D1 : D0;
    endfunction

    function automatic logic [DATA_W-1:0] rd_data(input logic [2:0] e);
        return ((e == 3'd2) || (e == 3'd4)) ? D1 : D0;
    endfunction

    assign start_ok  = START && ((state == S_IDLE) || (state == S_DONE));
    assign qual_fail = vld_p2 && !RESULT;
`ifdef MBIST_STOP_ON_FAIL_EN
    assign abort = qual_fail && ((state == S_RUN) || (state == S_DRAIN));
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // The registered WEN/REN/ADDR/elem describe the op on the bus; compute the following op.
    always_comb begin
        state_nxt     = state;
        elem_nxt      = elem;
        drain_nxt     = drain_cnt;
        addr_nxt      = ADDR;
        wen_nxt       = 1'b0;
        ren_nxt       = 1'b0;
        wdata_nxt     = WDATA;
        exp_nxt       = ExpDATA;
        fail_nxt      = FAIL;
        fail_addr_nxt = FAIL_ADDR;
        fail_elem_nxt = FAIL_ELEM;

        case (state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_nxt = S_RUN;
                    elem_nxt  = 3'd0;
                    addr_nxt  = '0;
                    wen_nxt   = 1'b1;
                end
            end
            S_RUN: begin
                if (elem == 3'd0) begin
                    if (ADDR == elem_last(elem)) begin
                        elem_nxt = 3'd1;
                        addr_nxt = elem_first(3'd1);
                        ren_nxt  = 1'b1;
                    end else begin
                        addr_nxt = ADDR + 1'b1;
                        wen_nxt  = 1'b1;
                    end
                end else if (elem == 3'd5) begin
                    if (ADDR == elem_last(elem)) begin
                        state_nxt = S_DRAIN;
                        drain_nxt = 1'b0;
                    end else begin
                        addr_nxt = ADDR + 1'b1;
                        ren_nxt  = 1'b1;
                    end
                end else if (REN) begin
                    wen_nxt = 1'b1;
                end else if (ADDR == elem_last(elem)) begin
                    elem_nxt = elem + 3'd1;
                    addr_nxt = elem_first(elem + 3'd1);
                    ren_nxt  = 1'b1;
                end else begin
                    addr_nxt = is_down(elem) ? ADDR - 1'b1 : ADDR + 1'b1;
                    ren_nxt  = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt) state_nxt = S_DONE;
                else           drain_nxt = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (wen_nxt) wdata_nxt = wr_data(elem_nxt);
        if (ren_nxt) exp_nxt   = rd_data(elem_nxt);

        if (abort) begin
            state_nxt = S_DONE;
            elem_nxt  = elem;
            addr_nxt  = ADDR;
            wen_nxt   = 1'b0;
            ren_nxt   = 1'b0;
            wdata_nxt = WDATA;
            exp_nxt   = ExpDATA;
        end

        // First failure wins; a restart from DONE wipes the record.
        if (start_ok) begin
            fail_nxt      = 1'b0;
            fail_addr_nxt = '0;
            fail_elem_nxt = 3'd0;
        end else if (qual_fail) begin
            fail_nxt = 1'b1;
            if (!FAIL) begin
                fail_addr_nxt = addr_p2;
                fail_elem_nxt = elem_p2;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            elem      <= 3'd0;
            drain_cnt <= 1'b0;
            ADDR      <= '0;
            WDATA     <= '0;
            WEN       <= 1'b0;
            REN       <= 1'b0;
            ExpDATA   <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            FAIL      <= 1'b0;
            FAIL_ADDR <= '0;
            FAIL_ELEM <= 3'd0;
        end else begin
            elem      <= elem_nxt;
            drain_cnt <= drain_nxt;
            ADDR      <= addr_nxt;
            WDATA     <= wdata_nxt;
            WEN       <= wen_nxt;
            REN       <= ren_nxt;
            ExpDATA   <= exp_nxt;
            BUSY      <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            DONE      <= (state_nxt == S_DONE);
            FAIL      <= fail_nxt;
            FAIL_ADDR <= fail_addr_nxt;
            FAIL_ELEM <= fail_elem_nxt;
        end
    end

    // Read-issue tracking: stage 2 lines up with the comparator's RESULT.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            addr_p1 <= '0;
            addr_p2 <= '0;
            elem_p1 <= 3'd0;
            elem_p2 <= 3'd0;
        end else if (abort) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
        end else begin
            vld_p1  <= REN;
            addr_p1 <= ADDR;
            elem_p1 <= elem;
            vld_p2  <= vld_p1;
            addr_p2 <= addr_p1;
            elem_p2 <= elem_p1;
        end
    end

endmodule

// File: tb/tb_mbist_march_gen.sv
// Directed bench for mbist_march_gen with an SRAM model, a registered comparator and a stuck-at fault option.
module tb_mbist_march_gen;

    localparam int N   = 16;
    localparam int OPS = 10 * N;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b1;
    logic       START = 1'b0;
    logic       RESULT = 1'b1;
    logic [3:0] ADDR;
    logic [7:0] WDATA;
    logic       WEN;
    logic       REN;
    logic [7:0] ExpDATA;
    logic       BUSY;
    logic       DONE;
    logic       FAIL;
    logic [3:0] FAIL_ADDR;
    logic [2:0] FAIL_ELEM;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] mem [N];
    logic [7:0] rdata = 8'h00;
    logic [7:0] exp_q = 8'h00;
    logic       fault_en = 1'b0;

    logic       ex_wen  [1:OPS];
    logic       ex_ren  [1:OPS];
    logic [3:0] ex_addr [1:OPS];
    logic [7:0] ex_data [1:OPS];

    mbist_march_gen dut (
        .CLK(CLK), .nRESET(nRESET), .START(START), .RESULT(RESULT),
        .ADDR(ADDR), .WDATA(WDATA), .WEN(WEN), .REN(REN), .ExpDATA(ExpDATA),
        .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL), .FAIL_ADDR(FAIL_ADDR), .FAIL_ELEM(FAIL_ELEM)
    );

    always #5 CLK = ~CLK;

    // SRAM with optional stuck-at-0 on bit 3 of word 5, followed by the comparator.
    always @(posedge CLK) begin
        if (WEN) mem[ADDR] <= WDATA;
        if (REN) rdata <= (fault_en && ADDR == 4'd5) ? (mem[ADDR] & 8'hF7) : mem[ADDR];
        exp_q  <= ExpDATA;
        RESULT <= (rdata == exp_q);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic build_ops();
        logic [7:0] rd_v [6] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
        logic [7:0] wr_v [6] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
        logic [3:0] a;
        int k = 1;
        for (int j = 0; j < N; j++) begin
            ex_wen[k] = 1'b1; ex_ren[k] = 1'b0; ex_addr[k] = 4'(j); ex_data[k] = 8'h00; k++;
        end
        for (int e = 1; e <= 4; e++) begin
            for (int j = 0; j < N; j++) begin
                a = (e >= 3) ? 4'(N - 1 - j) : 4'(j);
                ex_wen[k] = 1'b0; ex_ren[k] = 1'b1; ex_addr[k] = a; ex_data[k] = rd_v[e]; k++;
                ex_wen[k] = 1'b1; ex_ren[k] = 1'b0; ex_addr[k] = a; ex_data[k] = wr_v[e]; k++;
            end
        end
        for (int j = 0; j < N; j++) begin
            ex_wen[k] = 1'b0; ex_ren[k] = 1'b1; ex_addr[k] = 4'(j); ex_data[k] = 8'h00; k++;
        end
    endtask

    task automatic run_test(input bit fault, input int pulse_at, input int reset_at, input bit exp_fail);
        int stop_at;
        stop_at  = OPS + 3;
`ifdef MBIST_STOP_ON_FAIL_EN
        if (fault) stop_at = 62;
`endif
        fault_en = fault;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 0;
        cyc = 1;
        check("restart_clears", {29'd0, DONE, FAIL, (FAIL_ADDR != 4'd0 || FAIL_ELEM != 3'd0)}, 32'd0);
        for (int k = 1; k < stop_at; k++) begin
            cyc = k;
            if (k <= OPS) begin
                check("op", {BUSY, DONE, WEN, REN, ADDR, (ex_wen[k] ? WDATA : ExpDATA)},
                      {1'b1, 1'b0, ex_wen[k], ex_ren[k], ex_addr[k], ex_data[k]});
            end else begin
                check("drain", {BUSY, DONE, WEN, REN}, 4'b1000);
            end
            if (k == pulse_at) START = 1'b1;
            if (k == reset_at) begin
                #2 nRESET = 1'b0;
                #1;
                check("async_reset", {ADDR, WDATA, WEN, REN, ExpDATA, BUSY, DONE, FAIL, FAIL_ADDR, FAIL_ELEM}, 32'd0);
                return;
            end
            @(posedge CLK); #1;
            START = 1'b0;
        end
        cyc = stop_at;
        check("done", {BUSY, DONE, WEN, REN}, 4'b0100);
        check("fail", FAIL, exp_fail);
        check("fail_addr", FAIL_ADDR, exp_fail ? 32'd5 : 32'd0);
        check("fail_elem", FAIL_ELEM, exp_fail ? 32'd2 : 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            cyc++;
            check("done_hold", {BUSY, DONE, WEN, REN}, 4'b0100);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d observed=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        build_ops();
        #3 nRESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_bus", {ADDR, WDATA, WEN, REN, ExpDATA}, 32'd0);
        check("reset_status", {BUSY, DONE, FAIL, FAIL_ADDR, FAIL_ELEM}, 32'd0);
        nRESET = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        check("idle_no_start", {BUSY, DONE, WEN, REN}, 4'b0000);

        // Fault-free run with an ignored START at cycle 50.
        run_test(1'b0, 50, 0, 1'b0);
        // Stuck-at-0 on bit 3 at address 5 is first seen on the E2 read.
        run_test(1'b1, 0, 0, 1'b1);
        // Restart from DONE: flags cleared, identical fault-free rerun.
        run_test(1'b0, 0, 0, 1'b0);
        // Reset in the middle of a run.
        run_test(1'b0, 0, 70, 1'b0);
        @(posedge CLK); #1;
        check("reset_held", {BUSY, DONE, WEN, REN, FAIL}, 5'b00000);
        nRESET = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
        end
        check("post_reset_idle", {BUSY, DONE, WEN, REN, ADDR}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mbist_march_gen.md
Name: mbist_march_gen

Overview:
MBIST pattern generator and sequencer that runs a March C- test on a synchronous single-port SRAM. It drives the SRAM address, write data and read/write strobes, and supplies ExpDATA to the downstream comparator. ExpDATA is timed so the comparator's one-cycle ExpDATA register lines up with SRAM read data. The block consumes the comparator's registered RESULT and reports pass/fail plus the first failing address and March element.

Parameters:
ADDR_W, 4, SRAM address width; N = 2**ADDR_W words
DATA_W, 8, SRAM/comparator data width
BG_PATTERN, 8'h00, data background "0"; the "1" background is ~BG_PATTERN

Ports:
CLK  input  1  clock, rising edge
nRESET  input  1  asynchronous active-low reset
START  input  1  single-cycle pulse; starts a test when in IDLE or DONE
RESULT  input  1  comparator result (1 = match), valid 2 cycles after a read issue
ADDR  output  ADDR_W  SRAM address
WDATA  output  DATA_W  SRAM write data
WEN  output  1  SRAM write strobe
REN  output  1  SRAM read strobe
ExpDATA  output  DATA_W  expected data to comparator, valid in the read-issue cycle
BUSY  output  1  test in progress, including drain
DONE  output  1  test complete; held until next START or reset
FAIL  output  1  sticky; at least one qualified mismatch
FAIL_ADDR  output  ADDR_W  address of first mismatch
FAIL_ELEM  output  3  March element index (0-5) of first mismatch

Behaviour:
- Reset: all outputs 0; ExpDATA = 0; FSM = IDLE; internal pipelines cleared.
- All outputs are registered. Exactly one SRAM op per cycle. WEN and REN are never high together.
- March C- elements (D0 = BG_PATTERN, D1 = ~BG_PATTERN):
  - E0: up (w D0)
  - E1: up (r D0, w D1)
  - E2: up (r D1, w D0)
  - E3: down (r D0, w D1)
  - E4: down (r D1, w D0)
  - E5: up (r D0)
- "up" runs addresses 0..N-1; "down" runs N-1..0. Wrap-around ends the element; the address counter never rolls over into a repeat.
- In r/w elements, for each address: read cycle, then write cycle to the same address.
- Total op cycles = 10N (160 with defaults).
- FSM states:
  - IDLE: START -> RUN.
  - RUN: sequence E0..E5; after the last E5 read -> DRAIN.
  - DRAIN: exactly 2 cycles to collect the last RESULT -> DONE.
  - DONE: START -> RUN.
- START is sampled at edge e0. The first op (E0, w D0 @ addr 0) is driven in the cycle after e0.
- DONE rises in cycle 10N+3 after e0. BUSY is high from cycle 1 through 10N+2.
- START in RUN or DRAIN is ignored.
- START in DONE clears DONE, FAIL, FAIL_ADDR and FAIL_ELEM and restarts.
- Read pipeline: each read issue pushes {valid, ADDR, element} into a 2-stage shift register.
  - RESULT is sampled only when stage-2 valid = 1.
  - RESULT is ignored otherwise, including during reset release, write cycles and idle.
- On a qualified RESULT = 0:
  - FAIL is set.
  - FAIL_ADDR and FAIL_ELEM are captured only if FAIL was 0; the first failure wins.
  - The test continues.
- ExpDATA updates only in read-issue cycles and holds its value otherwise.
- Reset asserted mid-test: immediate return to reset values. The next test needs a new START.

Optional Feature:
MBIST_STOP_ON_FAIL_EN:
- When defined, the first qualified mismatch aborts the test: RUN/DRAIN -> DONE on the next edge, WEN/REN forced 0, FAIL/FAIL_ADDR/FAIL_ELEM captured as above.
- Ops already in the read pipeline are discarded.
- When not defined, the test always runs to completion (10N+2 cycles).

Test Plan:
- Fault-free SRAM model + comparator, START at e0 -> 160 ops, DONE high at cycle 163, BUSY low at 163, FAIL = 0.
- Stuck-at-0 on bit 3 at addr 5 -> FAIL = 1, FAIL_ADDR = 5, FAIL_ELEM = 2; DONE at cycle 163 with macro undefined.
- Address/order check: monitor ADDR/WEN/REN -> E3 and E4 visit 15..0; each address gets REN then WEN with WDATA = 8'hFF in E3 and 8'h00 in E4; ExpDATA = 8'h00 in E3 reads and 8'hFF in E4 reads.
- START pulsed at cycle 50 mid-run -> ignored, no timing change. START in DONE -> flags cleared, identical rerun.
- nRESET low at cycle 70 -> all outputs 0 asynchronously. After release, nothing happens without START.
- MBIST_STOP_ON_FAIL_EN defined, addr 5 stuck-at-0 -> DONE one cycle after the failing RESULT, FAIL_ELEM = 2, no further WEN/REN.
